// File: rtl/vxe_vpu_prod_eu_fetch.sv
// Product EU fetch stage: turns generator addresses into 64-bit reads and
// unpacks enabled 32-bit words of in-order responses into a word FIFO.
// Word credits guarantee every response has room, so responses never stall.
module vxe_vpu_prod_eu_fetch #(
    parameter int unsigned OUTST  = 4,
    parameter int unsigned WDEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_ag_valid,
    input  logic [36:0] i_ag_addr,
    input  logic [1:0]  i_ag_we_mask,
    output logic        o_ag_incr,
    output logic        o_rq_vld,
    output logic [36:0] o_rq_addr,
    input  logic        i_rq_rdy,
    input  logic        i_rs_vld,
    input  logic [63:0] i_rs_data,
    output logic        o_wd_vld,
    output logic [31:0] o_wd_data,
    input  logic        i_wd_rd,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned OAW = $clog2(OUTST);
    localparam int unsigned OPW = OAW + 1;
    localparam int unsigned WAW = $clog2(WDEPTH);
    localparam int unsigned WPW = WAW + 1;

    logic [OPW-1:0] mwp_q, mwp_d, mrp_q, mrp_d;
    logic [1:0]     mfifo_q [OUTST];
    logic [1:0]     mfifo_d [OUTST];
    logic [WPW-1:0] wwp_q, wwp_d, wrp_q, wrp_d;
    logic [31:0]    wmem_q [WDEPTH];
    logic [31:0]    wmem_d [WDEPTH];
    logic [WPW-1:0] res_q, res_d;
    logic           err_q, err_d;

    logic [OPW-1:0] outst;
    logic [WPW-1:0] wcnt;
    logic [1:0]     n_mask;
    logic           room;
    logic           fire;
    logic           rs_ok;
    logic [1:0]     rs_mask;
    logic           pop;
    logic [WAW-1:0] lo_idx, hi_idx;

    // Issue/pop qualification; nrst gating keeps the request side quiet in reset
    always_comb begin
        outst     = OPW'(mwp_q - mrp_q);
        wcnt      = WPW'(wwp_q - wrp_q);
        n_mask    = 2'(i_ag_we_mask[0]) + 2'(i_ag_we_mask[1]);
        room      = (({1'b0, res_q} + (WPW+1)'(n_mask)) <= (WPW+1)'(WDEPTH));
        o_rq_vld  = nrst & i_ag_valid & (|i_ag_we_mask) & (outst < OPW'(OUTST)) & room;
        o_rq_addr = i_ag_addr;
        fire      = o_rq_vld & i_rq_rdy;
        o_ag_incr = fire;
        rs_ok     = i_rs_vld & (outst != '0);
        rs_mask   = mfifo_q[mrp_q[OAW-1:0]];
        o_wd_vld  = (wcnt != '0);
        o_wd_data = wmem_q[wrp_q[WAW-1:0]];
        pop       = i_wd_rd & o_wd_vld;
        o_busy    = (outst != '0) | o_wd_vld;
        o_err     = err_q;
        lo_idx    = wwp_q[WAW-1:0];
        hi_idx    = WAW'(wwp_q[WAW-1:0] + WAW'(1));
    end

    // Next-state: mask FIFO push/pop, word unpack, credit and error tracking
    always_comb begin
        mwp_d   = mwp_q;
        mrp_d   = mrp_q;
        mfifo_d = mfifo_q;
        wwp_d   = wwp_q;
        wrp_d   = wrp_q;
        wmem_d  = wmem_q;
        res_d   = res_q;
        err_d   = err_q;

        if (fire) begin
            mfifo_d[mwp_q[OAW-1:0]] = i_ag_we_mask;
            mwp_d = OPW'(mwp_q + OPW'(1));
        end

        if (rs_ok) begin
            mrp_d = OPW'(mrp_q + OPW'(1));
            unique case (rs_mask)
                2'b01: begin
                    wmem_d[lo_idx] = i_rs_data[31:0];
                    wwp_d = WPW'(wwp_q + WPW'(1));
                end
                2'b10: begin
                    wmem_d[lo_idx] = i_rs_data[63:32];
                    wwp_d = WPW'(wwp_q + WPW'(1));
                end
                2'b11: begin
                    wmem_d[lo_idx] = i_rs_data[31:0];
                    wmem_d[hi_idx] = i_rs_data[63:32];
                    wwp_d = WPW'(wwp_q + WPW'(2));
                end
                default: ;
            endcase
        end else if (i_rs_vld) begin
            err_d = 1'b1;
        end

        if (pop) begin
            wrp_d = WPW'(wrp_q + WPW'(1));
        end

        res_d = WPW'(res_q + (fire ? WPW'(n_mask) : WPW'(0)) - (pop ? WPW'(1) : WPW'(0)));
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            mwp_q <= '0;
            mrp_q <= '0;
            wwp_q <= '0;
            wrp_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            mwp_q <= mwp_d;
            mrp_q <= mrp_d;
            wwp_q <= wwp_d;
            wrp_q <= wrp_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    // Storage arrays need no reset; pointers decide what is valid
    always_ff @(posedge clk) begin
        mfifo_q <= mfifo_d;
        wmem_q  <= wmem_d;
    end

endmodule

// File: tb/tb_vxe_vpu_prod_eu_fetch.sv
// Directed bench for the product EU fetch stage with a reference credit model
// and a word scoreboard filled from driven response data.
module tb_vxe_vpu_prod_eu_fetch;

    localparam int OUTST  = 4;
    localparam int WDEPTH = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_ag_valid;
    logic [36:0] i_ag_addr;
    logic [1:0]  i_ag_we_mask;
    logic        o_ag_incr;
    logic        o_rq_vld;
    logic [36:0] o_rq_addr;
    logic        i_rq_rdy;
    logic        i_rs_vld;
    logic [63:0] i_rs_data;
    logic        o_wd_vld;
    logic [31:0] o_wd_data;
    logic        i_wd_rd;
    logic        o_busy;
    logic        o_err;

    vxe_vpu_prod_eu_fetch #(.OUTST(OUTST), .WDEPTH(WDEPTH)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_ag_valid   (i_ag_valid),
        .i_ag_addr    (i_ag_addr),
        .i_ag_we_mask (i_ag_we_mask),
        .o_ag_incr    (o_ag_incr),
        .o_rq_vld     (o_rq_vld),
        .o_rq_addr    (o_rq_addr),
        .i_rq_rdy     (i_rq_rdy),
        .i_rs_vld     (i_rs_vld),
        .i_rs_data    (i_rs_data),
        .o_wd_vld     (o_wd_vld),
        .o_wd_data    (o_wd_data),
        .i_wd_rd      (i_wd_rd),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int dut_fires = 0;
    int f0;

    // reference model state
    int          m_out = 0;
    int          m_res = 0;
    logic        m_err = 1'b0;
    logic [1:0]  pend[$];
    logic [31:0] sb[$];
    int unsigned data_k = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] next_data();
        data_k++;
        return {32'(32'hB000_0000 + data_k * 2 + 1), 32'(32'hA000_0000 + data_k * 2)};
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model
    task automatic tick();
        int          n;
        logic        exp_vld, exp_fire, exp_pop;
        logic [1:0]  mk;
        logic [31:0] w;
        @(negedge clk);
        n        = int'(i_ag_we_mask[0]) + int'(i_ag_we_mask[1]);
        exp_vld  = nrst && i_ag_valid && (i_ag_we_mask != 2'b00) && (m_out < OUTST) && (m_res + n <= WDEPTH);
        exp_fire = exp_vld && i_rq_rdy;
        chk("rq_vld", 64'(o_rq_vld), 64'(exp_vld));
        chk("ag_incr", 64'(o_ag_incr), 64'(exp_fire));
        if (exp_vld) chk("rq_addr", 64'(o_rq_addr), 64'(i_ag_addr));
        chk("wd_vld", 64'(o_wd_vld), 64'(sb.size() != 0));
        chk("busy", 64'(o_busy), 64'((m_out != 0) || (sb.size() != 0)));
        chk("err", 64'(o_err), 64'(m_err));
        exp_pop = i_wd_rd && (sb.size() != 0);
        if (exp_pop) begin
            w = sb.pop_front();
            chk("wd_data", 64'(o_wd_data), 64'(w));
        end
        if (o_ag_incr) dut_fires++;
        if (!nrst) begin
            m_out = 0; m_res = 0; m_err = 1'b0;
            pend.delete(); sb.delete();
        end else begin
            if (i_rs_vld) begin
                if (m_out == 0) m_err = 1'b1;
                else begin
                    mk = pend.pop_front();
                    if (mk[0]) sb.push_back(i_rs_data[31:0]);
                    if (mk[1]) sb.push_back(i_rs_data[63:32]);
                    m_out--;
                end
            end
            if (exp_fire) begin
                pend.push_back(i_ag_we_mask);
                m_out++;
                m_res += n;
            end
            if (exp_pop) m_res--;
        end
        @(posedge clk);
        #1;
        if (exp_fire) i_ag_addr = i_ag_addr + 37'd1;
    endtask

    task automatic drain();
        i_ag_valid = 1'b0;
        i_wd_rd    = 1'b1;
        for (int i = 0; i < 24; i++) begin
            i_rs_vld  = (pend.size() != 0);
            i_rs_data = next_data();
            tick();
        end
        i_rs_vld = 1'b0;
        i_wd_rd  = 1'b0;
        tick();
        chk("drained_busy", 64'(o_busy), 64'(0));
    endtask

    initial begin
        nrst = 1'b0; i_ag_valid = 1'b0; i_ag_addr = 37'h100; i_ag_we_mask = 2'b11;
        i_rq_rdy = 1'b1; i_rs_vld = 1'b0; i_rs_data = '0; i_wd_rd = 1'b0;
        @(posedge clk); #1;
        tick(); tick();
        nrst = 1'b1;
        tick();

        // aligned vector, vlen=4
        i_ag_valid = 1'b1; i_ag_we_mask = 2'b11;
        tick(); tick();
        i_ag_valid = 1'b0;
        chk("aligned_fires", 64'(dut_fires), 64'(2));
        tick();
        i_rs_vld = 1'b1; i_rs_data = 64'h0000_0002_0000_0001; tick();
        i_rs_data = 64'h0000_0004_0000_0003; tick();
        i_rs_vld = 1'b0;
        i_wd_rd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_wd_rd = 1'b0;
        tick();

        // odd start: masks 10, 11, 01
        i_ag_valid = 1'b1;
        i_ag_we_mask = 2'b10; tick();
        i_ag_we_mask = 2'b11; tick();
        i_ag_we_mask = 2'b01; tick();
        i_ag_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_rs_vld = 1'b1; i_rs_data = next_data(); tick();
        end
        i_rs_vld = 1'b0;
        drain();

        // credit limit with mask 11 and no pops
        f0 = dut_fires;
        i_ag_valid = 1'b1; i_ag_we_mask = 2'b11; i_wd_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_rs_vld = (pend.size() != 0); i_rs_data = next_data(); tick();
        end
        i_rs_vld = 1'b0;
        chk("credit_fires", 64'(dut_fires - f0), 64'(4));
        i_wd_rd = 1'b1; tick();
        i_wd_rd = 1'b0; tick();
        chk("credit_pop1_blocked", 64'(dut_fires - f0), 64'(4));
        i_wd_rd = 1'b1; tick();
        i_wd_rd = 1'b0; tick();
        chk("credit_pop2_unblocks", 64'(dut_fires - f0), 64'(5));
        drain();

        // outstanding limit: memory silent
        f0 = dut_fires;
        i_ag_valid = 1'b1; i_ag_we_mask = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        chk("outst_fires", 64'(dut_fires - f0), 64'(OUTST));
        i_rs_vld = 1'b1; i_rs_data = next_data(); tick();
        i_rs_vld = 1'b0;
        chk("outst_same_cycle_blocked", 64'(dut_fires - f0), 64'(OUTST));
        tick();
        chk("outst_reenabled", 64'(dut_fires - f0), 64'(OUTST + 1));
        drain();

        // simultaneous fire, response and pop at res=6
        i_ag_valid = 1'b1; i_ag_we_mask = 2'b11;
        tick(); tick(); tick();
        i_ag_valid = 1'b0;
        i_rs_vld = 1'b1; i_rs_data = next_data(); tick();
        i_ag_valid = 1'b1; i_wd_rd = 1'b1; i_rs_data = next_data(); tick();
        i_ag_valid = 1'b0; i_rs_vld = 1'b0; i_wd_rd = 1'b0;
        tick();
        chk("simul_count", 64'(sb.size()), 64'(3));
        drain();

        // stray response then reset
        i_rs_vld = 1'b1; i_rs_data = next_data(); tick();
        i_rs_vld = 1'b0;
        tick();
        chk("stray_err", 64'(o_err), 64'(1));
        chk("stray_no_word", 64'(o_wd_vld), 64'(0));
        nrst = 1'b0; i_ag_valid = 1'b1; i_ag_we_mask = 2'b01;
        tick();
        nrst = 1'b1; i_ag_valid = 1'b0;
        tick();
        chk("rst_err", 64'(o_err), 64'(0));
        chk("rst_wd_vld", 64'(o_wd_vld), 64'(0));
        chk("rst_rq_vld", 64'(o_rq_vld), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vxe_vpu_prod_eu_fetch.md
Name: vxe_vpu_prod_eu_fetch

Overview:
- Fetch stage directly downstream of the product EU vector address generator.
- Consumes the generator's valid/address/word-mask stream and issues 64-bit read requests to the VPU memory port. Each request advances the generator by one step.
- Accepts in-order 64-bit responses and unpacks the enabled 32-bit words into a word FIFO that feeds the product datapath.
- Bounds reservations with a credit scheme, so a response always has buffer space and is never back-pressured.

Parameters:
- OUTST, 4, max outstanding read requests; power of 2, >=2.
- WDEPTH, 8, word FIFO depth in 32-bit words; power of 2, >=4.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- i_ag_valid  in  1  generator has a valid address
- i_ag_addr  in  37  64-bit-word address from generator
- i_ag_we_mask  in  2  enabled words: bit0 = low word, bit1 = high word
- o_ag_incr  out  1  advance generator (combinational)
- o_rq_vld  out  1  read request valid
- o_rq_addr  out  37  read request address (equals i_ag_addr)
- i_rq_rdy  in  1  memory accepts request
- i_rs_vld  in  1  read response valid; in order, no back-pressure
- i_rs_data  in  64  response data; [31:0] = low word
- o_wd_vld  out  1  word FIFO not empty
- o_wd_data  out  32  FIFO head word
- i_wd_rd  in  1  pop FIFO head
- o_busy  out  1  requests outstanding or words buffered
- o_err  out  1  sticky: response received with no request outstanding

Behaviour:
- All state updates on posedge clk. When nrst=0 at a clock edge: outstanding count, mask FIFO and word FIFO pointers, credit count and o_err are cleared. Mid-operation reset discards in-flight tracking; late responses after reset set o_err.
- Reset outputs: o_rq_vld=0, o_ag_incr=0, o_wd_vld=0, o_busy=0, o_err=0; o_wd_data don't-care.
- n(mask) = popcount(i_ag_we_mask), range 0..2. A mask of 00 is never issued; o_rq_vld is held 0 for it.
- Credits: res = words in word FIFO + words reserved by outstanding requests, range 0..WDEPTH.
- Issue condition: o_rq_vld = i_ag_valid & (mask != 00) & (outstanding < OUTST) & (res + n(mask) <= WDEPTH). Pure combinational, no registered stage.
- Handshake: fire = o_rq_vld & i_rq_rdy. On fire:
  - o_ag_incr=1 in the same cycle;
  - the mask is pushed to the mask FIFO (depth OUTST);
  - outstanding +1;
  - res += n(mask).
- o_rq_vld may deassert without a fire if the generator input changes; no stability requirement on the memory side.
- Response handling, on i_rs_vld:
  - pop the mask FIFO head;
  - mask 01: write i_rs_data[31:0];
  - mask 10: write i_rs_data[63:32];
  - mask 11: write low word at tail and high word at tail+1 in the same cycle (dual write port);
  - outstanding -1. res is unchanged, because reserved words convert to buffered words.
- Response with outstanding==0: data dropped, no FIFO change, o_err set until reset.
- Output: o_wd_vld = FIFO count != 0. On i_wd_rd & o_wd_vld: pop, res -1. i_wd_rd while empty is ignored.
- Simultaneous events in one cycle: issue, response and pop all take effect together.
  - res_next = res + n(issue) - pop.
  - outstanding_next = outstanding + fire - rs.
  - A response and a new issue in the same cycle are legal even with outstanding==OUTST: the issue check uses the current count, so it is blocked.
- Pointer wrap: the word FIFO uses log2(WDEPTH)+1-bit pointers with modulo wrap; the count is derived from the pointer difference. The mask FIFO is handled the same way.
- Credit saturation: res never exceeds WDEPTH by construction. Words on response are written unconditionally, so overflow is impossible.
- o_busy = (outstanding != 0) | o_wd_vld.
- Latency:
  - request issue: 0 cycles from i_ag_valid (combinational);
  - response to o_wd_vld: 1 cycle (registered FIFO write);
  - o_wd_data is valid from the FIFO head in the same cycle as o_wd_vld.

Test Plan:
- Aligned vector, vlen=4, i_rq_rdy=1, response 2 cycles after each request with data 0x0000000200000001 and 0x0000000400000003 -> two requests, o_ag_incr pulses twice; words 1,2,3,4 popped in order; o_busy returns 0.
- Odd start with mask sequence 10, 11, 01 -> three requests; words popped: high of beat 0, low and high of beat 1, low of beat 2; res returns to 0.
- i_wd_rd=0, continuous mask 11, WDEPTH=8 -> exactly 4 requests issued, then o_rq_vld=0. Popping one word does not unblock (res=7). Popping two words permits one more request.
- Memory never responds, i_rq_rdy=1, masks 01 -> o_rq_vld drops after OUTST=4 fires. One response re-enables issue on the next cycle.
- Same-cycle fire, response and pop with res=6 and mask 11 -> res_next=7, outstanding unchanged, FIFO count +1 net; data order preserved.
- i_rs_vld pulse with nothing outstanding -> o_err=1, FIFO unchanged. Drive nrst=0 for one clock -> o_err=0, o_wd_vld=0, o_rq_vld=0.
